decode_sb: RTL
==============

# decode_sb

Parametrised decode-stage core for the pipelined CPU: a register file with write-back bypass, a per-register scoreboard of outstanding writes, and a valid/ready-handshaked ID/EX output register. It sits between fetch and execute and receives the write-back port from the last stage. Its RAW/WAW stalls replace the instruction-compare duplicate-write suppression of the previous decode generation. Operand data, destination, immediate and control bits leave through the output register.

## Interface
Parameters:
- DATA_W, 16: register and data width
- NREGS, 8: number of architectural registers (power of two, ≥2)
- RSEL_W, $clog2(NREGS): register-select width
- CTRL_W, 24: opaque control bundle width, passed through unchanged
- MAX_PEND, 3: maximum outstanding writes per register (≥1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  instruction accepted this cycle
- in_rs1, in_rs2  input  RSEL_W  source selects
- in_use1, in_use2  input  1  source actually read
- in_rd  input  RSEL_W  destination select
- in_rd_we  input  1  instruction writes in_rd
- in_imm  input  DATA_W  extended immediate
- in_ctrl  input  CTRL_W  control bundle
- out_valid  output  1  output register holds an instruction
- out_ready  input  1  execute accepts
- out_rs1_data, out_rs2_data  output  DATA_W  operand values
- out_rd  output  RSEL_W;  out_rd_we  output  1
- out_imm  output  DATA_W;  out_ctrl  output  CTRL_W
- wb_we  input  1;  wb_sel  input  RSEL_W;  wb_data  input  DATA_W  write-back port
- flush  input  1  kill the instruction in the output register
- sb_err  output  1  sticky: write-back to a register with zero pending

## Operation
- Register file: NREGS×DATA_W flops; the write on wb_we occurs at the clock edge. Every register is hardwired-free; r0 is ordinary.
- Scoreboard: pend[r] counter, width $clog2(MAX_PEND+1).
  - Issue (in_valid & in_ready & in_rd_we) increments pend[in_rd].
  - wb_we decrements pend[wb_sel].
  - Issue and write-back to the same register in the same cycle leave pend unchanged.
  - wb_we with pend[wb_sel]==0: counter stays 0; sb_err sets and holds until reset.
- Hazard (stall) is asserted on any of:
  - RAW: in_useN and pend[in_rsN]!=0, except when the clear condition under Configuration applies.
  - WAW overflow: in_rd_we and pend[in_rd]==MAX_PEND, and there is no same-cycle wb to in_rd.
- in_ready = ~flush & ~hazard & (~out_valid | out_ready). in_ready is combinational.
- On accept, the output register loads operands, in_rd, in_rd_we, in_imm and in_ctrl, and out_valid is set.
- When out_valid & out_ready with no new accept, out_valid clears.
- Flush:
  - out_valid clears next edge.
  - If the flushed instruction had out_rd_we, pend[out_rd] decrements. Combined with a same-cycle wb to that register, the net change is −2, floored at 0.
  - Flush blocks acceptance in its cycle.
- Output data holds while out_valid & ~out_ready.

## Timing
- Accept to out_valid: 1 cycle. Throughput is 1 instruction/cycle with no hazards.
- Write-back data enters the array at the edge. It is readable by a same-cycle accept only via bypass.
- Reset (rst low, asynchronous):
  - all registers, all pend counters, out_valid, out_rd_we and sb_err go to 0
  - every output data field goes to 0
- A reset in the middle of a stall drops the held instruction. After reset release, the first accept is possible on the first edge.

## Configuration
- DECODE_SB_BYPASS_EN defined:
  - A source read whose select matches wb_sel while wb_we=1 returns wb_data.
  - RAW clears when pend==1 and that write-back is present in the same cycle.
- Undefined:
  - Reads return array contents only.
  - RAW stalls until pend==0, one cycle longer per dependency.
  - The WAW rule is unchanged.

## Structure
- Shared package decode_sb_pkg holds:
  - default DATA_W, NREGS and MAX_PEND constants
  - the ctrl-bundle field offsets consumed by execute
- One sub-module, sb_regfile: the array plus 2 read ports and the optional bypass muxes. The scoreboard, hazard logic and output register stay in decode_sb.

## Test plan
- Reset, then wb r3=16'hBEEF, then issue with rs1=3 → out_rs1_data=16'hBEEF next cycle, pend all 0.
- Issue rd=2 write, then an rs1=2 reader → in_ready=0 until wb r2. With BYPASS_EN it is accepted in the wb cycle with the wb_data value; without it, one cycle later.
- MAX_PEND=3: three issues writing r5 with no wb, then a fourth → stalled. wb r5 the next cycle → the fourth is accepted in that same cycle.
- out_ready=0 for 4 cycles with out_valid=1 → outputs stable and in_ready=0. out_ready=1 → one transfer, then the next instruction.
- Issue rd=4, then flush while it sits in the output register → out_valid=0 next cycle and pend[4]=0. A later reader of r4 is not stalled.
- wb r6 with pend[6]=0 → sb_err=1 and stays 1; pend[6] stays 0. rst low mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/decode_sb_pkg.sv
// Shared constants for the decode stage: default geometry, control-bundle field offsets
// and the scoreboard counter update helper.
package decode_sb_pkg;

  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefNregs   = 8;
  localparam int unsigned DefCtrlW   = 24;
  localparam int unsigned DefMaxPend = 3;

  // Control-bundle layout consumed by execute; decode passes the bundle through untouched.
  localparam int unsigned CtrlAluOpLsb  = 0;
  localparam int unsigned CtrlAluOpW    = 5;
  localparam int unsigned CtrlSrcImmBit = 5;
  localparam int unsigned CtrlMemRdBit  = 6;
  localparam int unsigned CtrlMemWrBit  = 7;
  localparam int unsigned CtrlBrLsb     = 8;
  localparam int unsigned CtrlBrW       = 3;
  localparam int unsigned CtrlFuncLsb   = 11;
  localparam int unsigned CtrlFuncW     = 13;

  // Net counter change for one register, floored at zero.
  function automatic int pend_update(input int cur, input logic inc, input logic dec_wb,
                                     input logic dec_kill);
    int v;
    v = cur;
    if (inc) v = v + 1;
    if (dec_wb) v = v - 1;
    if (dec_kill) v = v - 1;
    if (v < 0) v = 0;
    return v;
  endfunction

endpackage

// File: rtl/decode_sb_regfile.sv
// Register array with two combinational read ports.
// DECODE_SB_BYPASS_EN forwards same-cycle write-back data to matching reads.
module sb_regfile
  import decode_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned NREGS  = DefNregs,
  parameter int unsigned RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RSEL_W-1:0] wsel,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RSEL_W-1:0] rs1,
  input  logic [RSEL_W-1:0] rs2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wsel] <= wdata;
    end
  end

`ifdef DECODE_SB_BYPASS_EN
  assign rdata1 = (we && (wsel == rs1)) ? wdata : regs_q[rs1];
  assign rdata2 = (we && (wsel == rs2)) ? wdata : regs_q[rs2];
`else
  assign rdata1 = regs_q[rs1];
  assign rdata2 = regs_q[rs2];
`endif

endmodule

// File: rtl/decode_sb.sv
// Decode stage: register file, per-register pending-write scoreboard and ID/EX output register.
// DECODE_SB_BYPASS_EN enables write-back forwarding and early RAW release.
module decode_sb
  import decode_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NREGS    = DefNregs,
  parameter int unsigned RSEL_W   = $clog2(NREGS),
  parameter int unsigned CTRL_W   = DefCtrlW,
  parameter int unsigned MAX_PEND = DefMaxPend
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RSEL_W-1:0] in_rs1,
  input  logic [RSEL_W-1:0] in_rs2,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [RSEL_W-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [RSEL_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic [DATA_W-1:0] out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              wb_we,
  input  logic [RSEL_W-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              sb_err
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PendMax = PEND_W'(MAX_PEND);

  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic              err_q, err_d;

  logic              valid_q;
  logic [DATA_W-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [RSEL_W-1:0] rd_q;
  logic              rd_we_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic [DATA_W-1:0] rdata1, rdata2;
  logic              raw1, raw2, raw_clr1, raw_clr2, waw, hazard, accept, kill_wr;

  sb_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .RSEL_W (RSEL_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .wsel   (wb_sel),
    .wdata  (wb_data),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

`ifdef DECODE_SB_BYPASS_EN
  // The last outstanding write retiring this cycle is forwarded, so no stall is needed.
  assign raw_clr1 = wb_we && (wb_sel == in_rs1) && (pend_q[in_rs1] == PEND_W'(1));
  assign raw_clr2 = wb_we && (wb_sel == in_rs2) && (pend_q[in_rs2] == PEND_W'(1));
`else
  assign raw_clr1 = 1'b0;
  assign raw_clr2 = 1'b0;
`endif

  assign raw1   = in_use1 && (pend_q[in_rs1] != '0) && !raw_clr1;
  assign raw2   = in_use2 && (pend_q[in_rs2] != '0) && !raw_clr2;
  assign waw    = in_rd_we && (pend_q[in_rd] == PendMax) && !(wb_we && (wb_sel == in_rd));
  assign hazard = raw1 || raw2 || waw;

  assign in_ready = !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign kill_wr  = flush && valid_q && rd_we_q;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = PEND_W'(pend_update(int'(pend_q[r]),
                                      accept && in_rd_we && (in_rd == RSEL_W'(r)),
                                      wb_we && (wb_sel == RSEL_W'(r)),
                                      kill_wr && (rd_q == RSEL_W'(r))));
    end
    err_d = err_q || (wb_we && (pend_q[wb_sel] == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
      err_q <= err_d;
    end
  end

  // Flush has priority over a handshake; accept is already blocked by it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      ctrl_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      rs1_data_q <= rdata1;
      rs2_data_q <= rdata2;
      imm_q      <= in_imm;
      rd_q       <= in_rd;
      rd_we_q    <= in_rd_we;
      ctrl_q     <= in_ctrl;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_rd_we    = rd_we_q;
  assign out_ctrl     = ctrl_q;
  assign sb_err       = err_q;

endmodule
